// File: rtl/masked_hpc2_mul_pipe_pkg.sv
// Shared helpers for the HPC2 masked multiplier: multiplier mode, randomness indexing
// and the GF(2^w) reduction polynomials used by the GF product.
package aes128_package;
  typedef enum logic {MUL_AND = 1'b0, MUL_GF = 1'b1} mul_mode_e;

  function automatic int num_quad(input int n);
    return n * (n - 1) / 2;
  endfunction

  // R_{i,j} and R_{j,i} are one random word; the diagonal maps to 0 and is never consumed.
  function automatic int qindex(input int i, input int j, input int n);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    if (lo == hi) return 0;
    return lo * n - lo * (lo + 1) / 2 + hi - lo - 1;
  endfunction

  // Reduction term of the field polynomial, with the x^w term dropped.
  function automatic logic [31:0] gf_poly(input int w);
    case (w)
      1:       return 32'h1;
      2:       return 32'h3;
      3:       return 32'h3;
      4:       return 32'h3;
      5:       return 32'h5;
      6:       return 32'h3;
      7:       return 32'h3;
      8:       return 32'h1b;
      default: return 32'h3;
    endcase
  endfunction
endpackage

// File: rtl/masked_hpc2_mul_pipe_share_unit.sv
// One output share of the HPC2 gadget: row-i U/W partial products (stage t1)
// and the XOR reduction of the registered row into C_i (stage t2).
module hpc2_share_unit
  import aes128_package::*;
#(
  parameter int        NUM_SHARES = 2,
  parameter int        BIT_WIDTH  = 1,
  parameter mul_mode_e MUL_MODE   = MUL_AND
) (
  input  logic [BIT_WIDTH-1:0]                 a,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] opr,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] rnd,
  output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] u,
  output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] w,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] u_reg,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] w_reg,
  output logic [BIT_WIDTH-1:0]                 c
);
  localparam logic [BIT_WIDTH-1:0] POLY = BIT_WIDTH'(gf_poly(BIT_WIDTH));

  function automatic logic [BIT_WIDTH-1:0] generic_mul(input logic [BIT_WIDTH-1:0] x,
                                                       input logic [BIT_WIDTH-1:0] y);
    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH-1:0] sh;
    logic                 msb;
    acc = '0;
    sh  = x;
    msb = 1'b0;
    if (MUL_MODE == MUL_AND) begin
      acc = x & y;
    end else begin
      for (int k = 0; k < BIT_WIDTH; k++) begin
        if (y[k]) acc = acc ^ sh;
        msb = sh[BIT_WIDTH-1];
        sh  = (sh << 1) ^ (msb ? POLY : '0);
      end
    end
    return acc;
  endfunction

  // Diagonal of opr carries Reg(B_i) and rnd is zero there, so W_{i,i} is always 0.
  always_comb begin
    u = '0;
    w = '0;
    for (int j = 0; j < NUM_SHARES; j++) begin
      u[j] = generic_mul(a, opr[j]);
      w[j] = generic_mul(a, rnd[j]) ^ rnd[j];
    end
  end

  always_comb begin
    c = '0;
    for (int j = 0; j < NUM_SHARES; j++) c = c ^ u_reg[j] ^ w_reg[j];
  end
endmodule

// File: rtl/masked_hpc2_mul_pipe.sv
// Two-stage flow-controlled HPC2 masked multiplier; in_enable=0 freezes every register
// so in-flight operations resume exactly and no randomness is consumed twice.
module masked_hpc2_mul_pipe
  import aes128_package::*;
#(
  parameter int        NUM_SHARES = 2,
  parameter int        BIT_WIDTH  = 1,
  parameter mul_mode_e MUL_MODE   = MUL_AND
) (
  input  logic                                        in_clock,
  input  logic                                        in_reset,
  input  logic                                        in_enable,
  input  logic                                        in_valid,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]             in_b,
  input  logic [num_quad(NUM_SHARES)*BIT_WIDTH-1:0]   in_r,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]             in_a,
  output logic                                        out_a_req,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]             out_c,
  output logic                                        out_valid
);
  localparam int N = NUM_SHARES;
  localparam int W = BIT_WIDTH;
  localparam int Q = num_quad(NUM_SHARES);

  logic [N-1:0][N-1:0][W-1:0] v_q;
  logic [Q-1:0][W-1:0]        r_q;
  logic [N-1:0][N-1:0][W-1:0] rr;
  logic [N-1:0][N-1:0][W-1:0] u_d, w_d, u_q, w_q;
  logic [N-1:0][W-1:0]        c_share;
  logic                       valid_t1, valid_t2;

  // v_q diagonal holds Reg(B_i); off-diagonal holds Reg(B_j ^ R_{i,j}).
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      v_q      <= '0;
      r_q      <= '0;
      u_q      <= '0;
      w_q      <= '0;
      valid_t1 <= 1'b0;
      valid_t2 <= 1'b0;
    end else if (in_enable) begin
      valid_t1 <= in_valid;
      valid_t2 <= valid_t1;
      if (in_valid) begin
        r_q <= in_r;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            v_q[i][j] <= (i == j) ? in_b[i*W +: W]
                                  : in_b[j*W +: W] ^ in_r[qindex(i, j, N)*W +: W];
          end
        end
      end
      if (valid_t1) begin
        u_q <= u_d;
        w_q <= w_d;
      end
    end
  end

  always_comb begin
    rr = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i != j) rr[i][j] = r_q[qindex(i, j, N)];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_share
    hpc2_share_unit #(
      .NUM_SHARES(N),
      .BIT_WIDTH (W),
      .MUL_MODE  (MUL_MODE)
    ) u_unit (
      .a    (in_a[i*W +: W]),
      .opr  (v_q[i]),
      .rnd  (rr[i]),
      .u    (u_d[i]),
      .w    (w_d[i]),
      .u_reg(u_q[i]),
      .w_reg(w_q[i]),
      .c    (c_share[i])
    );
    assign out_c[i*W +: W] = valid_t2 ? c_share[i] : '0;
  end

  assign out_a_req = valid_t1;
  assign out_valid = valid_t2;
endmodule
